// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential word reads to instruction memory,
// queues returned words with their PCs and hands them to decode over valid/ready.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            clr,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Stale fetches still draining after redirects can push the in-flight total
    // past DEPTH for a while, so the in-flight counters get extra headroom.
    localparam int OW = PW + 4;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0] fifo_data_q [DEPTH];
    logic [XLEN-1:0] fifo_data_d [DEPTH];
    logic [XLEN-1:0] fifo_pc_q [DEPTH];
    logic [XLEN-1:0] fifo_pc_d [DEPTH];

    logic [XLEN-1:0] redirect_pc_aligned;
    logic [OW-1:0]   live_cnt;
    logic            req_fire;
    logic            resp_drop;
    logic            push;
    logic            pop;

    assign redirect_pc_aligned = redirect_pc & ~XLEN'(3);

    // Credit covers words already queued plus live (non-dropped) fetches.
    assign live_cnt       = OW'(count_q) + outstanding_q - drop_cnt_q;
    assign imem_req_valid = clr && (live_cnt < OW'(DEPTH)) && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_drop = imem_resp_valid && (drop_cnt_q != '0);
    assign push      = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;

    assign inst_valid = clr && (count_q != '0);
    assign inst_data  = fifo_data_q[rd_ptr_q];
    assign inst_pc    = fifo_pc_q[rd_ptr_q];
    assign pop        = inst_valid && inst_ready && !redirect_valid;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_data_d   = fifo_data_q;
        fifo_pc_d     = fifo_pc_q;

        if (redirect_valid) begin
            fetch_pc_d    = redirect_pc_aligned;
            resp_pc_d     = redirect_pc_aligned;
            outstanding_d = outstanding_q - OW'(imem_resp_valid);
            drop_cnt_d    = outstanding_q - OW'(imem_resp_valid);
            count_d       = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            outstanding_d = outstanding_q + OW'(req_fire) - OW'(imem_resp_valid);
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - OW'(1);
            end
            if (push) begin
                fifo_data_d[wr_ptr_q] = imem_resp_data;
                fifo_pc_d[wr_ptr_q]   = resp_pc_q;
                resp_pc_d             = resp_pc_q + XLEN'(4);
                wr_ptr_d              = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
        fifo_pc_q   <= fifo_pc_d;
    end

    push_not_full_a: assert property (@(posedge clk) disable iff (!clr)
        !(push && (count_q == CW'(DEPTH))));

endmodule
